ex_branch_resolve: RTL and testbench



---
 rtl/branch_pckg.sv | 26 ++
 rtl/branch_bht.sv | 42 ++++
 rtl/ex_branch_resolve.sv | 153 +++++++++++++++
 tb/tb_ex_branch_resolve.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pckg.sv
// Shared types and constants for EX-stage branch resolution and the branch history table.
package branch_pckg;

  typedef enum logic [2:0] {
    BR_JAL  = 3'd0,
    BR_JALR = 3'd1,
    BR_BEQ  = 3'd2,
    BR_BNE  = 3'd3,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_op_e;

  localparam logic [1:0] BHT_RESET = 2'b01;
  localparam logic [1:0] SAT_MIN   = 2'b00;
  localparam logic [1:0] SAT_MAX   = 2'b11;

  localparam int STEP_COMPR = 2;
  localparam int STEP_FULL  = 4;

  function automatic logic is_cond_br(input br_op_e op);
    return (op != BR_JAL) && (op != BR_JALR);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// 2-bit saturating branch history table: combinational lookup, synchronous training.
module branch_bht
  import branch_pckg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d [ENTRIES];

  // Lookup reads the registered array, so a same-cycle update is not bypassed.
  assign o_rd_taken = cnt_q[i_rd_idx][1];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) cnt_d[i] = cnt_q[i];
    if (i_wr_en) begin
      if (i_wr_taken) begin
        if (cnt_q[i_wr_idx] != SAT_MAX) cnt_d[i_wr_idx] = cnt_q[i_wr_idx] + 2'b01;
      end else begin
        if (cnt_q[i_wr_idx] != SAT_MIN) cnt_d[i_wr_idx] = cnt_q[i_wr_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_RESET;
    end else begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// Registered EX branch/jump resolution with mispredict redirect and BHT training.
// Optional performance counters are enabled with BR_PERF_CNT_EN.
module ex_branch_resolve
  import branch_pckg::*;
#(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  br_op_e          i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_is_compr,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_fetch_pred_taken,
  output logic            o_valid,
  output logic [XLEN-1:0] o_link_data,
  output logic            o_link_wr,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0] fallthrough, br_target, jalr_target, target;
  logic            taken, mispred, accept, cond;

  logic            valid_q, valid_d;
  logic            link_wr_q, link_wr_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] link_data_q, link_data_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_fetch_pc[XLEN-1:IDX_W+1], i_fetch_pc[0],
                            i_pc[XLEN-1:IDX_W+1], i_pc[0]};

  always_comb begin
    fallthrough = i_pc + (i_is_compr ? XLEN'(STEP_COMPR) : XLEN'(STEP_FULL));
    br_target   = i_pc + (i_imm << 1);
    jalr_target = (i_rs1 + i_imm) & ~XLEN'(1);
    target      = br_target;
    taken       = 1'b0;
    unique case (i_op)
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin taken = 1'b1; target = jalr_target; end
      BR_BEQ:  taken = (i_rs1 == i_rs2);
      BR_BNE:  taken = (i_rs1 != i_rs2);
      BR_BLT:  taken = ($signed(i_rs1) <  $signed(i_rs2));
      BR_BGE:  taken = ($signed(i_rs1) >= $signed(i_rs2));
      BR_BLTU: taken = (i_rs1 <  i_rs2);
      BR_BGEU: taken = (i_rs1 >= i_rs2);
      default: taken = 1'b0;
    endcase
    mispred = (taken != i_pred_taken) || (taken && (target != i_pred_target));
    cond    = is_cond_br(i_op);
    accept  = i_valid && !i_stall && !i_flush;
  end

  always_comb begin
    valid_d       = valid_q;
    link_wr_d     = link_wr_q;
    link_data_d   = link_data_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = 1'b0;
    if (i_flush) begin
      valid_d   = 1'b0;
      link_wr_d = 1'b0;
    end else if (i_stall) begin
      valid_d   = valid_q;
    end else if (i_valid) begin
      valid_d       = 1'b1;
      link_wr_d     = !cond;
      link_data_d   = fallthrough;
      redirect_pc_d = taken ? target : fallthrough;
      redirect_d    = mispred;
    end else begin
      valid_d   = 1'b0;
      link_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      link_wr_q     <= 1'b0;
      redirect_q    <= 1'b0;
      link_data_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      link_wr_q     <= link_wr_d;
      redirect_q    <= redirect_d;
      link_data_q   <= link_data_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_link_wr     = link_wr_q;
  assign o_link_data   = link_data_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;

  branch_bht #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (i_fetch_pc[IDX_W:1]),
    .o_rd_taken (o_fetch_pred_taken),
    .i_wr_en    (accept && cond),
    .i_wr_idx   (i_pc[IDX_W:1]),
    .i_wr_taken (taken)
  );

`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept && cond) br_cnt_d      = br_cnt_q + CNT_W'(1);
    if (accept && mispred) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`else
  assign o_br_cnt      = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed self-checking bench for ex_branch_resolve (XLEN=64, 16-entry BHT).
module tb_ex_branch_resolve;
  import branch_pckg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  br_op_e          i_op;
  logic [XLEN-1:0] i_pc, i_rs1, i_rs2, i_imm, i_pred_target, i_fetch_pc;
  logic            i_is_compr, i_pred_taken, i_stall, i_flush;
  logic            o_fetch_pred_taken, o_valid, o_link_wr, o_redirect;
  logic [XLEN-1:0] o_link_data, o_redirect_pc;
  logic [CNT_W-1:0] o_br_cnt, o_mispred_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_br = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  ex_branch_resolve #(.XLEN(XLEN), .BHT_ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_op(i_op), .i_pc(i_pc),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_is_compr(i_is_compr),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .i_stall(i_stall), .i_flush(i_flush), .i_fetch_pc(i_fetch_pc),
    .o_fetch_pred_taken(o_fetch_pred_taken), .o_valid(o_valid),
    .o_link_data(o_link_data), .o_link_wr(o_link_wr), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef BR_PERF_CNT_EN
    chk({tag, "_br_cnt"}, 64'(o_br_cnt), 64'(exp_br));
    chk({tag, "_mis_cnt"}, 64'(o_mispred_cnt), 64'(exp_mis));
`else
    chk({tag, "_br_cnt"}, 64'(o_br_cnt), 64'd0);
    chk({tag, "_mis_cnt"}, 64'(o_mispred_cnt), 64'd0);
`endif
  endtask

  task automatic drive(input br_op_e op, input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm, input logic compr,
                       input logic ptaken, input logic [63:0] ptarget);
    i_valid = 1'b1; i_op = op; i_pc = pc; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    i_is_compr = compr; i_pred_taken = ptaken; i_pred_target = ptarget;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_op = BR_JAL; i_pc = '0; i_rs1 = '0; i_rs2 = '0;
    i_imm = '0; i_is_compr = 1'b0; i_pred_taken = 1'b0; i_pred_target = '0;
    i_stall = 1'b0; i_flush = 1'b0; i_fetch_pc = '0;

    // Reset state
    step(); step();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_redirect", 64'(o_redirect), 64'd0);
    chk("rst_link_wr", 64'(o_link_wr), 64'd0);
    chk("rst_redirect_pc", o_redirect_pc, 64'd0);
    chk_cnt("rst");
    for (int i = 0; i < 16; i++) begin
      i_fetch_pc = 64'(i * 2);
      #1;
      chk("rst_bht_pred", 64'(o_fetch_pred_taken), 64'd0);
    end
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken -> redirect to 0x110
    drive(BR_BEQ, 64'h100, 64'd5, 64'd5, 64'h8, 1'b0, 1'b0, 64'h0);
    i_fetch_pc = 64'h100;
    step(); exp_br++; exp_mis++;
    i_valid = 1'b0;
    chk("beq_redirect", 64'(o_redirect), 64'd1);
    chk("beq_redirect_pc", o_redirect_pc, 64'h110);
    chk("beq_valid", 64'(o_valid), 64'd1);
    chk("beq_link_wr", 64'(o_link_wr), 64'd0);
    chk("beq_bht_trained", 64'(o_fetch_pred_taken), 64'd1);
    step();
    chk("beq_redirect_clear", 64'(o_redirect), 64'd0);
    chk("beq_valid_clear", 64'(o_valid), 64'd0);

    // BLT signed taken, correctly predicted; then BLTU back-to-back, not taken
    drive(BR_BLT, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 1'b1, 64'h320);
    step(); exp_br++;
    chk("blt_redirect", 64'(o_redirect), 64'd0);
    chk("blt_redirect_pc", o_redirect_pc, 64'h320);
    drive(BR_BLTU, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 1'b0, 64'h0);
    step(); exp_br++;
    chk("bltu_redirect", 64'(o_redirect), 64'd0);
    chk("bltu_valid", 64'(o_valid), 64'd1);
    chk("bltu_redirect_pc", o_redirect_pc, 64'h304);

    // Compressed JALR, mispredicted
    drive(BR_JALR, 64'h200, 64'h1003, 64'd0, 64'd0, 1'b1, 1'b0, 64'h0);
    step(); exp_mis++;
    chk("jalr_link_data", o_link_data, 64'h202);
    chk("jalr_link_wr", 64'(o_link_wr), 64'd1);
    chk("jalr_redirect_pc", o_redirect_pc, 64'h1002);
    chk("jalr_redirect", 64'(o_redirect), 64'd1);

    // JAL with negative offset wrapping below zero, correctly predicted
    drive(BR_JAL, 64'h0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    i_valid = 1'b0;
    chk("jal_redirect", 64'(o_redirect), 64'd0);
    chk("jal_redirect_pc", o_redirect_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_link_data", o_link_data, 64'h4);
    chk_cnt("phase1");

    // Fresh BHT: taken BNE x3 at 0x40 then two not-taken
    rst_n = 1'b0; exp_br = 0; exp_mis = 0;
    step();
    rst_n = 1'b1;
    i_fetch_pc = 64'h40;
    drive(BR_BNE, 64'h40, 64'd1, 64'd2, 64'h4, 1'b0, 1'b1, 64'h48);
    #1;
    chk("bne_pred_pre", 64'(o_fetch_pred_taken), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(); exp_br++;
      chk("bne_taken_pred", 64'(o_fetch_pred_taken), 64'd1);
      chk("bne_taken_redirect", 64'(o_redirect), 64'd0);
    end
    drive(BR_BNE, 64'h40, 64'd2, 64'd2, 64'h4, 1'b0, 1'b0, 64'h0);
    step(); exp_br++;
    chk("bne_nt1_pred", 64'(o_fetch_pred_taken), 64'd1);
    chk("bne_nt1_redirect_pc", o_redirect_pc, 64'h44);
    step(); exp_br++;
    chk("bne_nt2_pred", 64'(o_fetch_pred_taken), 64'd0);

    // Mispredict accepted, then stall: redirect pulses once, output held
    i_fetch_pc = 64'h80;
    drive(BR_BEQ, 64'h80, 64'd7, 64'd7, 64'h2, 1'b0, 1'b0, 64'h0);
    step(); exp_br++; exp_mis++;
    chk("stall_acc_redirect", 64'(o_redirect), 64'd1);
    chk("stall_acc_pc", o_redirect_pc, 64'h84);
    chk("stall_acc_pred", 64'(o_fetch_pred_taken), 64'd1);
    drive(BR_BNE, 64'h80, 64'd3, 64'd3, 64'h2, 1'b0, 1'b1, 64'h84);
    i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_redirect", 64'(o_redirect), 64'd0);
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_pc_held", o_redirect_pc, 64'h84);
      chk("stall_bht_held", 64'(o_fetch_pred_taken), 64'd1);
    end

    // Flush with valid input: nothing consumed
    i_stall = 1'b0; i_flush = 1'b1;
    step();
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_redirect", 64'(o_redirect), 64'd0);
    chk("flush_link_wr", 64'(o_link_wr), 64'd0);
    chk("flush_bht_held", 64'(o_fetch_pred_taken), 64'd1);
    i_flush = 1'b0; i_valid = 1'b0;
    step();
    chk_cnt("phase2");

    // Reset while a mispredict result is stalled
    drive(BR_BEQ, 64'h80, 64'd7, 64'd7, 64'h2, 1'b0, 1'b0, 64'h0);
    step();
    i_stall = 1'b1; rst_n = 1'b0;
    step(); exp_br = 0; exp_mis = 0;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_redirect", 64'(o_redirect), 64'd0);
    chk("rst_mid_bht", 64'(o_fetch_pred_taken), 64'd0);
    chk_cnt("rst_mid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
